write_back_stack_unit: RTL and testbench

WRITE_BACK_STACK_UNIT -- requirements
Module: write_back_stack_unit

---
 rtl/write_back_stack_unit.sv | 117 +++++++++++
 tb/tb_write_back_stack_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/write_back_stack_unit.sv
// Write-back stage with a small LIFO that can capture results (push) or supply them (pop).
// Optional sticky overflow/underflow flags are built when WB_STACK_ERR_FLAGS_EN is defined.
module write_back_stack_unit #(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       writeBackEn,
   input  logic                       memRead,
   input  logic [31:0]                address,
   input  logic [31:0]                memOut,
   input  logic [3:0]                 destination,
   input  logic                       pushEn,
   input  logic                       popEn,
   output logic                       wbEn,
   output logic [3:0]                 wbDest,
   output logic [31:0]                wbValue,
   output logic [$clog2(DEPTH):0]     stackCount,
   output logic                       stackFull,
   output logic                       stackEmpty,
   output logic                       stackOverflow,
   output logic                       stackUnderflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   result;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;
   logic [CW-1:0] top_full;
   logic [AW-1:0] top_idx;
   logic [AW-1:0] wr_idx;
   logic          wr_en;
   logic [31:0]   stack_top;
   logic [31:0]   mem_reg [DEPTH];

   assign result     = memRead ? memOut : address;
   assign stackEmpty = (count_reg == '0);
   assign stackFull  = (count_reg == CW'(DEPTH));
   assign stackCount = count_reg;
   assign top_full   = count_reg - CW'(1);
   assign top_idx    = top_full[AW-1:0];
   assign stack_top  = mem_reg[top_idx];
   assign wbDest     = destination;

   // A pop from an empty stack never asserts the write enable.
   always_comb begin
      wbEn    = writeBackEn;
      wbValue = result;
      if (popEn) begin
         if (!stackEmpty) begin
            wbEn    = 1'b1;
            wbValue = stack_top;
         end else begin
            wbEn    = 1'b0;
         end
      end
   end

   // Push+pop on a non-empty stack replaces the top in place; on an empty stack it is a plain push.
   always_comb begin
      wr_en      = 1'b0;
      wr_idx     = count_reg[AW-1:0];
      count_next = count_reg;
      if (pushEn && popEn && !stackEmpty) begin
         wr_en  = 1'b1;
         wr_idx = top_idx;
      end else if (pushEn && !stackFull) begin
         wr_en      = 1'b1;
         count_next = count_reg + CW'(1);
      end else if (popEn && !pushEn && !stackEmpty) begin
         count_next = count_reg - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   // Storage is deliberately left unreset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem_reg[wr_idx] <= result;
      end
   end

`ifdef WB_STACK_ERR_FLAGS_EN
   logic overflow_reg;
   logic underflow_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (pushEn && !popEn && stackFull) begin
            overflow_reg <= 1'b1;
         end
         if (popEn && stackEmpty) begin
            underflow_reg <= 1'b1;
         end
      end
   end

   assign stackOverflow  = overflow_reg;
   assign stackUnderflow = underflow_reg;
`else
   assign stackOverflow  = 1'b0;
   assign stackUnderflow = 1'b0;
`endif

endmodule

// File: tb/tb_write_back_stack_unit.sv
// Directed, table-driven bench for write_back_stack_unit (DEPTH=8), plus hand-written
// sequences for reset-during-push and combinational write-back behaviour.
module tb_write_back_stack_unit;

   localparam int DEPTH = 8;
`ifdef WB_STACK_ERR_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        writeBackEn;
   logic        memRead;
   logic [31:0] address;
   logic [31:0] memOut;
   logic [3:0]  destination;
   logic        pushEn;
   logic        popEn;
   logic        wbEn;
   logic [3:0]  wbDest;
   logic [31:0] wbValue;
   logic [3:0]  stackCount;
   logic        stackFull;
   logic        stackEmpty;
   logic        stackOverflow;
   logic        stackUnderflow;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   write_back_stack_unit #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .writeBackEn    (writeBackEn),
      .memRead        (memRead),
      .address        (address),
      .memOut         (memOut),
      .destination    (destination),
      .pushEn         (pushEn),
      .popEn          (popEn),
      .wbEn           (wbEn),
      .wbDest         (wbDest),
      .wbValue        (wbValue),
      .stackCount     (stackCount),
      .stackFull      (stackFull),
      .stackEmpty     (stackEmpty),
      .stackOverflow  (stackOverflow),
      .stackUnderflow (stackUnderflow)
   );

   // Expected values describe the state before the edge that ends the vector's cycle.
   typedef struct {
      logic        rst;
      logic        wbe;
      logic        mr;
      logic [31:0] addr;
      logic [31:0] mo;
      logic [3:0]  dst;
      logic        push;
      logic        pop;
      logic        ewb;
      logic [31:0] eval;
      int          ecnt;
      logic        eovf;
      logic        eunf;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic wbe, input logic mr, input logic [31:0] a,
                      input logic [3:0] d, input logic pu, input logic po, input logic ewb,
                      input logic [31:0] ev, input int ec, input logic eo, input logic eu);
      vec_t v;
      v.rst = r; v.wbe = wbe; v.mr = mr; v.addr = a; v.mo = 32'hDEAD_BEEF; v.dst = d;
      v.push = pu; v.pop = po; v.ewb = ewb; v.eval = ev; v.ecnt = ec; v.eovf = eo; v.eunf = eu;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_state(input string tag, input int ec, input logic eo, input logic eu);
      check({tag, " count"}, 32'(stackCount), 32'(ec));
      check({tag, " full"}, 32'(stackFull), 32'(ec == DEPTH));
      check({tag, " empty"}, 32'(stackEmpty), 32'(ec == 0));
      check({tag, " ovf"}, 32'(stackOverflow), 32'(eo & FLAGS));
      check({tag, " unf"}, 32'(stackUnderflow), 32'(eu & FLAGS));
   endtask

   task automatic drive(input logic r, input logic wbe, input logic mr, input logic [31:0] a,
                        input logic [31:0] mo, input logic [3:0] d, input logic pu, input logic po);
      rst = r; writeBackEn = wbe; memRead = mr; address = a; memOut = mo;
      destination = d; pushEn = pu; popEn = po;
   endtask

   initial begin
      // rst wbe mr addr dst push pop | wbEn value count ovf unf
      add(0, 1, 0, 32'h0000_1234, 4'd5, 0, 0, 1, 32'h0000_1234, 0, 0, 0);
      vecs[0].mo = 32'h5555_AAAA;
      add(0, 1, 1, 32'h0000_1234, 4'd5, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
      add(0, 0, 0, 32'h0000_0000, 4'd9, 0, 0, 0, 32'h0000_0000, 0, 0, 0);
      add(0, 1, 0, 32'h0000_0055, 4'd3, 0, 1, 0, 32'h0000_0055, 0, 0, 0);
      add(0, 0, 0, 32'h0000_0011, 4'd0, 1, 0, 0, 32'h0000_0011, 0, 0, 1);
      add(0, 0, 0, 32'h0000_0022, 4'd0, 1, 0, 0, 32'h0000_0022, 1, 0, 1);
      add(0, 0, 0, 32'h0000_0033, 4'd0, 1, 0, 0, 32'h0000_0033, 2, 0, 1);
      add(0, 0, 0, 32'h0000_0000, 4'd2, 0, 1, 1, 32'h0000_0033, 3, 0, 1);
      add(0, 0, 0, 32'h0000_0000, 4'd2, 0, 1, 1, 32'h0000_0022, 2, 0, 1);
      add(0, 0, 0, 32'h0000_0000, 4'd2, 0, 1, 1, 32'h0000_0011, 1, 0, 1);
      add(0, 0, 0, 32'h0000_0000, 4'd0, 0, 0, 0, 32'h0000_0000, 0, 0, 1);
      add(0, 0, 0, 32'h0000_000A, 4'd0, 1, 0, 0, 32'h0000_000A, 0, 0, 1);
      add(0, 0, 0, 32'h0000_000B, 4'd0, 1, 0, 0, 32'h0000_000B, 1, 0, 1);
      add(0, 0, 0, 32'h0000_000C, 4'd7, 1, 1, 1, 32'h0000_000B, 2, 0, 1);
      add(0, 0, 0, 32'h0000_0000, 4'd7, 0, 1, 1, 32'h0000_000C, 2, 0, 1);
      add(0, 0, 0, 32'h0000_0000, 4'd7, 0, 1, 1, 32'h0000_000A, 1, 0, 1);
      add(0, 0, 0, 32'h0000_0000, 4'd0, 0, 0, 0, 32'h0000_0000, 0, 0, 1);
      add(0, 1, 0, 32'h0000_0077, 4'd1, 1, 1, 0, 32'h0000_0077, 0, 0, 1);
      add(0, 0, 0, 32'h0000_0000, 4'd1, 0, 1, 1, 32'h0000_0077, 1, 0, 1);
      add(0, 0, 0, 32'h0000_0000, 4'd0, 0, 0, 0, 32'h0000_0000, 0, 0, 1);
      add(1, 1, 0, 32'h0000_0005, 4'd4, 0, 0, 1, 32'h0000_0005, 0, 0, 1);
      add(0, 0, 0, 32'h0000_0000, 4'd0, 0, 0, 0, 32'h0000_0000, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         add(0, 0, 0, 32'(i), 4'd0, 1, 0, 0, 32'(i), i, 0, 0);
      end
      add(0, 0, 0, 32'h0000_0099, 4'd0, 1, 0, 0, 32'h0000_0099, 8, 0, 0);
      add(0, 0, 0, 32'h0000_0000, 4'd6, 0, 1, 1, 32'h0000_0007, 8, 1, 0);
      add(0, 0, 0, 32'h0000_0000, 4'd6, 0, 1, 1, 32'h0000_0006, 7, 1, 0);
      add(0, 0, 0, 32'h0000_0000, 4'd6, 0, 1, 1, 32'h0000_0005, 6, 1, 0);

      drive(1, 0, 0, 32'h0, 32'h0, 4'd0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      drive(0, 0, 0, 32'h0, 32'h0, 4'd0, 0, 0);
      #1;
      $display("reset: count=%0d empty=%0b", stackCount, stackEmpty);
      check_state("reset", 0, 0, 0);
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].wbe, vecs[i].mr, vecs[i].addr, vecs[i].mo,
               vecs[i].dst, vecs[i].push, vecs[i].pop);
         #1;
         $display("vec %0d: push=%0b pop=%0b wbEn=%0b wbValue=%h count=%0d",
                  i, pushEn, popEn, wbEn, wbValue, stackCount);
         check($sformatf("vec%0d wbEn", i), 32'(wbEn), 32'(vecs[i].ewb));
         check($sformatf("vec%0d wbValue", i), wbValue, vecs[i].eval);
         check($sformatf("vec%0d wbDest", i), 32'(wbDest), 32'(vecs[i].dst));
         check_state($sformatf("vec%0d", i), vecs[i].ecnt, vecs[i].eovf, vecs[i].eunf);
         @(negedge clk);
      end

      // Count is 5 with overflow set; reset coincides with a push.
      drive(1, 0, 0, 32'h0000_0044, 32'h0, 4'd3, 1, 0);
      #1;
      check_state("rstpush pre", 5, 1, 0);
      @(negedge clk);
      drive(0, 1, 0, 32'h0000_0001, 32'h0, 4'd3, 0, 1);
      #1;
      $display("rstpush: count=%0d wbEn=%0b wbValue=%h", stackCount, wbEn, wbValue);
      check_state("rstpush post", 0, 0, 0);
      check("rstpush pop wbEn", 32'(wbEn), 32'h0);
      check("rstpush pop wbValue", wbValue, 32'h0000_0001);
      @(negedge clk);
      drive(0, 1, 0, 32'h0000_0100, 32'h0, 4'd8, 0, 0);
      #1;
      check_state("after pop", 0, 0, 1);

      // Write-back path must follow input changes within the cycle.
      check("comb a", wbValue, 32'h0000_0100);
      address = 32'h0000_0200;
      #1;
      check("comb b", wbValue, 32'h0000_0200);
      memRead = 1'b1; memOut = 32'hCAFE_F00D;
      #1;
      $display("comb: wbValue=%h wbEn=%0b", wbValue, wbEn);
      check("comb c", wbValue, 32'hCAFE_F00D);
      check("comb wbEn", 32'(wbEn), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
